// File: rtl/nf10_input_arbiter_sched.sv
// Packet-granular weighted round-robin grant sequencer for the 5-port NF10 input arbiter.
// Optional per-port packet counters: define NF10_INPUT_ARBITER_SCHED_PKT_CNT_EN.
module nf10_input_arbiter_sched #(
  parameter int NUM_PORTS    = 5,
  parameter int IDX_WIDTH    = 3,
  parameter int WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 axi_aclk,
  input  logic                 axi_reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 pkt_done,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_rd_en,
  input  logic [3:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  output logic                 cfg_rvalid
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [IDX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d, credit_dec;
  logic [WEIGHT_WIDTH-1:0] weight_q [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0] weight_d [NUM_PORTS];
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [IDX_WIDTH-1:0]    win_idx;
  logic [WEIGHT_WIDTH-1:0] win_weight;
  logic                    win_found, take_win;
  logic                    unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:WEIGHT_WIDTH];

  // Rotating priority: offset 1 from ptr is best, ptr itself (offset NUM_PORTS) is last.
  always_comb begin : search
    int best_off;
    int off;
    best_off   = NUM_PORTS + 1;
    off        = 0;
    win_idx    = ptr_q;
    win_weight = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      off = (i > int'(ptr_q)) ? i - int'(ptr_q) : i - int'(ptr_q) + NUM_PORTS;
      if (req[i] && off < best_off) begin
        best_off = off;
        win_idx  = IDX_WIDTH'(i);
      end
    end
    win_found = (best_off <= NUM_PORTS);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == IDX_WIDTH'(i)) win_weight = weight_q[i];
    end
    if (win_weight == '0) win_weight = WEIGHT_WIDTH'(1);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= IDX_WIDTH'(NUM_PORTS - 1);
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
    end
  end

  // The owner keeps the stream until pkt_done, regardless of its req.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    credit_dec  = credit_q - WEIGHT_WIDTH'(1);
    take_win    = 1'b0;
    case (state_q)
      IDLE: take_win = win_found;
      BUSY: begin
        if (pkt_done) begin
          if (credit_dec != '0 && req[ptr_q]) begin
            credit_d = credit_dec;
          end else if (win_found) begin
            take_win = 1'b1;
          end else begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
            credit_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_win) begin
      state_d     = BUSY;
      grant_d     = NUM_PORTS'(1) << win_idx;
      grant_idx_d = win_idx;
      ptr_d       = win_idx;
      credit_d    = win_weight;
    end
  end

  always_comb begin
    grant       = grant_q;
    grant_idx   = grant_idx_q;
    grant_valid = (state_q == BUSY);
    cfg_rdata   = rdata_q;
    cfg_rvalid  = rvalid_q;
  end

`ifdef NF10_INPUT_ARBITER_SCHED_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

  // A clear written in the same cycle as an increment wins.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == BUSY && pkt_done && ptr_q == IDX_WIDTH'(i)) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      if (cfg_wr_en && cfg_addr == 4'(8 + i)) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (axi_reset) cnt_q[i] <= '0;
      else           cnt_q[i] <= cnt_d[i];
    end
  end
`endif

  // Weights are only sampled at credit reload, so a write never disturbs the current turn.
  always_comb begin
    rvalid_d = cfg_rd_en;
    rdata_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      weight_d[i] = weight_q[i];
      if (cfg_wr_en && cfg_addr == 4'(i)) weight_d[i] = cfg_wdata[WEIGHT_WIDTH-1:0];
    end
    if (cfg_rd_en) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cfg_addr == 4'(i)) rdata_d = 32'(weight_q[i]);
`ifdef NF10_INPUT_ARBITER_SCHED_PKT_CNT_EN
        if (cfg_addr == 4'(8 + i)) rdata_d = 32'(cnt_q[i]);
`endif
      end
      if (cfg_addr == 4'd15) rdata_d = 32'({(state_q == BUSY), grant_idx_q});
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) weight_q[i] <= WEIGHT_WIDTH'(1);
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NUM_PORTS; i++) weight_q[i] <= weight_d[i];
    end
  end

endmodule

// File: tb/tb_nf10_input_arbiter_sched.sv
// Directed self-checking bench for nf10_input_arbiter_sched.
// Inputs change just after the falling edge; outputs are checked on the falling edge.
module tb_nf10_input_arbiter_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic        pkt_done;
  logic [4:0]  grant;
  logic [2:0]  grant_idx;
  logic        grant_valid;
  logic        cfg_wr_en, cfg_rd_en;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        cfg_rvalid;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  nf10_input_arbiter_sched dut (
    .axi_aclk    (clk),
    .axi_reset   (rst),
    .req         (req),
    .pkt_done    (pkt_done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_rd_en   (cfg_rd_en),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .cfg_rvalid  (cfg_rvalid)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive req/pkt_done for one clock cycle.
  task automatic applyStimulus(input logic [4:0] reqV, input logic doneV);
    req      = reqV;
    pkt_done = doneV;
    @(negedge clk);
    pkt_done = 1'b0;
  endtask

  // A packet of len beats; pkt_done on the last beat.
  task automatic runPacket(input logic [4:0] reqV, input int len);
    for (int i = 0; i < len - 1; i++) applyStimulus(reqV, 1'b0);
    applyStimulus(reqV, 1'b1);
  endtask

  task automatic checkGrant(input string tag, input int idx);
    checkOutput({tag, " valid"}, 32'(grant_valid), 32'd1);
    checkOutput({tag, " idx"}, 32'(grant_idx), 32'(idx));
    checkOutput({tag, " onehot"}, 32'(grant), 32'd1 << idx);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " valid"}, 32'(grant_valid), 32'd0);
    checkOutput({tag, " grant"}, 32'(grant), 32'd0);
    checkOutput({tag, " idx"}, 32'(grant_idx), 32'd0);
  endtask

  task automatic cfgWrite(input logic [3:0] addr, input logic [31:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfgRead(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    cfg_rd_en = 1'b1;
    cfg_addr  = addr;
    @(negedge clk);
    cfg_rd_en = 1'b0;
    checkOutput({tag, " rvalid"}, 32'(cfg_rvalid), 32'd1);
    checkOutput(tag, cfg_rdata, expected);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Main directed sequence: each block sets up its own starting pointer via reset or prior grants.
  initial begin
    int seqA[5];
    int seqB[7];
    logic [31:0] expCnt;
    seqA = '{1, 2, 3, 4, 0};
    seqB = '{0, 0, 2, 0, 0, 0, 2};
    rst = 1'b1; req = '0; pkt_done = 1'b0;
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and idle behaviour.
    for (int i = 0; i < 10; i++) applyStimulus(5'b00000, 1'b0);
    checkIdle("reset");
    checkOutput("reset rdata", cfg_rdata, 32'd0);
    checkOutput("reset rvalid", 32'(cfg_rvalid), 32'd0);
    for (int a = 0; a < 5; a++) cfgRead($sformatf("weight%0d default", a), 4'(a), 32'd1);
    cfgRead("unmapped addr6", 4'd6, 32'd0);
    cfgRead("status idle", 4'd15, 32'd0);

    // Full request, unit weights: plain rotation with no bubble.
    applyStimulus(5'b11111, 1'b0);
    checkGrant("rr first", 0);
    for (int k = 0; k < 5; k++) begin
      runPacket(5'b11111, 4);
      checkGrant($sformatf("rr pkt%0d", k), seqA[k]);
    end
    runPacket(5'b00000, 2);
    checkIdle("rr drain");
    applyStimulus(5'b00000, 1'b1);
    checkIdle("pkt_done in idle");

    // Weight 3 on port 0 against port 2.
    pulseReset();
    cfgWrite(4'd0, 32'd3);
    cfgRead("weight0 rb", 4'd0, 32'd3);
    applyStimulus(5'b00101, 1'b0);
    checkGrant("wrr first", 0);
    for (int k = 0; k < 7; k++) begin
      runPacket(5'b00101, 2);
      checkGrant($sformatf("wrr pkt%0d", k), seqB[k]);
    end
    runPacket(5'b00000, 2);
    checkIdle("wrr drain");

    // Lone requester with weight 0 (treated as 1) is re-granted indefinitely.
    cfgWrite(4'd3, 32'd0);
    cfgRead("weight3 zero rb", 4'd3, 32'd0);
    applyStimulus(5'b01000, 1'b0);
    checkGrant("lone first", 3);
    for (int k = 0; k < 6; k++) begin
      runPacket(5'b01000, 3);
      checkGrant($sformatf("lone pkt%0d", k), 3);
    end
    runPacket(5'b00000, 1);
    checkIdle("lone drain");

    // Owner drops req mid-packet, then reset mid-packet.
    applyStimulus(5'b00010, 1'b0);
    checkGrant("hold first", 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(5'b00000, 1'b0);
      checkGrant($sformatf("hold beat%0d", k), 1);
    end
    applyStimulus(5'b00000, 1'b1);
    checkIdle("hold end");
    applyStimulus(5'b00111, 1'b0);
    checkGrant("pre-reset", 2);
    applyStimulus(5'b00111, 1'b0);
    rst = 1'b1;
    applyStimulus(5'b00111, 1'b0);
    checkIdle("mid-pkt reset");
    rst = 1'b0;
    applyStimulus(5'b00111, 1'b0);
    checkGrant("post-reset", 0);

    // Weight write coinciding with pkt_done reloads the old weight.
    req = 5'b00001; pkt_done = 1'b1;
    cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'd3;
    @(negedge clk);
    pkt_done = 1'b0; cfg_wr_en = 1'b0;
    checkGrant("oldw regrant", 0);
    runPacket(5'b00011, 2);
    checkGrant("oldw used", 1);
    for (int k = 0; k < 3; k++) begin
      runPacket(5'b00011, 2);
      checkGrant($sformatf("neww pkt%0d", k), 0);
    end
    runPacket(5'b00011, 2);
    checkGrant("neww rotate", 1);
    runPacket(5'b00000, 2);
    checkIdle("oldw drain");

    // Packet counters (read 0 when not built).
    pulseReset();
`ifdef NF10_INPUT_ARBITER_SCHED_PKT_CNT_EN
    expCnt = 32'd7;
`else
    expCnt = 32'd0;
`endif
    cfgWrite(4'd10, 32'd0);
    cfgRead("cnt2 cleared", 4'd10, 32'd0);
    applyStimulus(5'b00100, 1'b0);
    checkGrant("cnt first", 2);
    cfgRead("status busy", 4'd15, 32'hA);
    for (int k = 0; k < 7; k++) runPacket(5'b00100, 2);
    checkGrant("cnt after pkts", 2);
    cfgRead("cnt2 value", 4'd10, expCnt);
    cfgRead("cnt0 value", 4'd8, 32'd0);
    cfgWrite(4'd10, 32'd5);
    cfgRead("cnt2 after clear", 4'd10, 32'd0);
    cfgRead("weight4 intact", 4'd4, 32'd1);
    runPacket(5'b00000, 2);
    checkIdle("final drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
